// File: rtl/acc_sequencer_pkg.sv
// Shared constants, opcodes and FSM encoding for the accumulator sequencer.
// Default widths come from DATA_WIDTH / OPCODEWORD_ALU_OPCODE_WIDTH macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OPCODEWORD_ALU_OPCODE_WIDTH
`define OPCODEWORD_ALU_OPCODE_WIDTH 5
`endif

package acc_sequencer_pkg;

  localparam int STATUS_WIDTH = 4;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_ALU  = 2'd1;
  localparam logic [1:0] CMD_READ = 2'd2;
  localparam logic [1:0] CMD_NOP  = 2'd3;

  // Common ALU opcode table (subset used here)
  localparam logic [4:0] ALU_OP_LD  = 5'h00;
  localparam logic [4:0] ALU_OP_ADD = 5'h01;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/acc_strobe_gen.sv
// Negedge-registered WE / ALU_EN strobes so the accumulator's gated clock
// (clk & strobe) never sees an edge-coincident enable change.
module acc_strobe_gen
  import acc_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  state_t     i_state,
  input  logic [1:0] i_type,
  output logic       o_we,
  output logic       o_alu_en
);

  logic r_we;
  logic r_alu_en;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_alu_en <= 1'b0;
    end else begin
      r_we     <= (i_state == S_STROBE) && (i_type == CMD_LOAD);
      r_alu_en <= (i_state == S_STROBE) && (i_type == CMD_ALU);
    end
  end

  assign o_we     = r_we;
  assign o_alu_en = r_alu_en;

endmodule

// File: rtl/acc_sequencer.sv
// Command sequencer driving accumulator control pins with timed strobes.
// ACC_SEQ_STATUS_LATCH_EN: latch ALU status into rsp_status (else tied 0).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OPCODEWORD_ALU_OPCODE_WIDTH
`define OPCODEWORD_ALU_OPCODE_WIDTH 5
`endif

module acc_sequencer
  import acc_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int OPCODE_WIDTH = `OPCODEWORD_ALU_OPCODE_WIDTH,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [DATA_WIDTH-1:0]   cmd_operand,
  input  logic [CNT_WIDTH-1:0]    cmd_count,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [STATUS_WIDTH-1:0] rsp_status,
  output logic                    acc_cs,
  output logic                    acc_we,
  output logic                    acc_oe,
  output logic                    acc_alu_en,
  output logic [OPCODE_WIDTH-1:0] acc_alu_opcode,
  output logic [DATA_WIDTH-1:0]   acc_alu_input,
  output logic [DATA_WIDTH-1:0]   acc_bus_data,
  output logic                    acc_bus_drive,
  input  logic [DATA_WIDTH-1:0]   acc_data_out,
  input  logic [STATUS_WIDTH-1:0] acc_status
);

  localparam logic [OPCODE_WIDTH-1:0] OP_LD =
    OPCODE_WIDTH'(ALU_OP_LD);

  state_t r_state;
  state_t w_next;

  logic [1:0]              r_type;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_cs_oe;
  logic                    r_bus_drive;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0]   r_alu_input;
  logic [DATA_WIDTH-1:0]   r_bus_data;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;

  logic                    w_cmd_hs;
  logic                    w_rsp_hs;
  logic                    w_last;
  logic [1:0]              w_type;
  logic                    w_busy;
  logic                    w_cs_oe;
  logic                    w_bus_drive;
  logic [OPCODE_WIDTH-1:0] w_opcode;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_cmd_hs  = cmd_valid & cmd_ready;
  assign w_rsp_hs  = r_rsp_valid & rsp_ready;
  assign w_last    = (r_cnt == CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid)
          w_next = (cmd_type == CMD_NOP) ? S_RESP : S_SETUP;
      end
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: if (w_last) w_next = S_RESP;
      S_RESP:   if (w_rsp_hs) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Next values of the posedge control outputs, keyed off the next state
  always_comb begin
    w_type      = (r_state == S_IDLE) ? cmd_type : r_type;
    w_busy      = (w_next == S_SETUP) || (w_next == S_STROBE);
    w_cs_oe     = w_busy && (w_type == CMD_READ);
    w_bus_drive = w_busy && (w_type == CMD_LOAD);
    w_opcode    = OP_LD;
    if (w_busy && (w_type == CMD_ALU))
      w_opcode = (r_state == S_IDLE) ? cmd_opcode : r_opcode;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_type      <= CMD_LOAD;
      r_cnt       <= '0;
      r_cs_oe     <= 1'b0;
      r_bus_drive <= 1'b0;
      r_opcode    <= OP_LD;
      r_alu_input <= '0;
      r_bus_data  <= '0;
    end else begin
      r_cs_oe     <= w_cs_oe;
      r_bus_drive <= w_bus_drive;
      r_opcode    <= w_opcode;
      if (w_cmd_hs) begin
        r_type <= cmd_type;
        r_cnt  <= (cmd_type == CMD_ALU && cmd_count != '0) ?
                  cmd_count : CNT_WIDTH'(1);
        if (cmd_type == CMD_LOAD) r_bus_data  <= cmd_operand;
        if (cmd_type == CMD_ALU)  r_alu_input <= cmd_operand;
      end else if (r_state == S_STROBE) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Response is captured one cycle into RESP so Q reflects the last strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (r_state == S_RESP && !r_rsp_valid) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= acc_data_out;
    end else if (w_rsp_hs) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef ACC_SEQ_STATUS_LATCH_EN
  logic [STATUS_WIDTH-1:0] r_status;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_status <= '0;
    else if (r_state == S_STROBE && r_type == CMD_ALU && w_last)
      r_status <= acc_status;
  end

  assign rsp_status = r_status;
`else
  logic w_unused_status;
  assign w_unused_status = ^acc_status;
  assign rsp_status      = '0;
`endif

  acc_strobe_gen u_strobe (
    .clk      (clk),
    .reset    (reset),
    .i_state  (r_state),
    .i_type   (r_type),
    .o_we     (acc_we),
    .o_alu_en (acc_alu_en)
  );

  assign acc_cs         = r_cs_oe;
  assign acc_oe         = r_cs_oe;
  assign acc_bus_drive  = r_bus_drive;
  assign acc_bus_data   = r_bus_data;
  assign acc_alu_input  = r_alu_input;
  assign acc_alu_opcode = r_opcode;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a behavioural accumulator model.
// Status expectations follow ACC_SEQ_STATUS_LATCH_EN.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_acc_sequencer;
  import acc_sequencer_pkg::*;

  localparam int DW = 8;
  localparam int OW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = 2'd0;
  logic [OW-1:0] cmd_opcode = '0;
  logic [DW-1:0] cmd_operand = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [3:0]    rsp_status;
  logic          acc_cs, acc_we, acc_oe, acc_alu_en;
  logic [OW-1:0] acc_alu_opcode;
  logic [DW-1:0] acc_alu_input;
  logic [DW-1:0] acc_bus_data;
  logic          acc_bus_drive;
  logic [DW-1:0] acc_data_out;
  logic [3:0]    acc_status;

  int checks = 0;
  int errors = 0;
  int we_p = 0;
  int alu_p = 0;
  int both_p = 0;

  acc_sequencer #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_opcode(cmd_opcode),
    .cmd_operand(cmd_operand), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .acc_cs(acc_cs), .acc_we(acc_we), .acc_oe(acc_oe),
    .acc_alu_en(acc_alu_en), .acc_alu_opcode(acc_alu_opcode),
    .acc_alu_input(acc_alu_input), .acc_bus_data(acc_bus_data),
    .acc_bus_drive(acc_bus_drive), .acc_data_out(acc_data_out),
    .acc_status(acc_status)
  );

  always #5 clk = ~clk;

  // Accumulator model: status = {ovf, neg, carry, zero}
  logic [DW-1:0] q;
  logic [DW:0]   sum;
  logic [DW-1:0] res;
  logic          carry, ovf;

  always_comb begin
    sum   = {1'b0, q} + {1'b0, acc_alu_input};
    res   = acc_alu_input;
    carry = 1'b0;
    ovf   = 1'b0;
    if (acc_alu_opcode == ALU_OP_ADD) begin
      res   = sum[DW-1:0];
      carry = sum[DW];
      ovf   = (q[DW-1] == acc_alu_input[DW-1]) &&
              (res[DW-1] != q[DW-1]);
    end
  end

  assign acc_status   = {ovf, res[DW-1], carry, (res == '0)};
  assign acc_data_out = q;

  always @(posedge clk) begin
    if (acc_we)
      q <= (acc_bus_drive && acc_alu_opcode == ALU_OP_LD) ?
           acc_bus_data : 'x;
    else if (acc_alu_en)
      q <= res;
    if (acc_we) we_p++;
    if (acc_alu_en) alu_p++;
    if (acc_we && acc_alu_en) both_p++;
  end

  task automatic start(input logic [1:0] t, input logic [OW-1:0] op,
                       input logic [DW-1:0] d, input logic [CW-1:0] n);
    `CHK("cmd_ready_idle", cmd_ready, 1'b1)
    cmd_valid   = 1'b1;
    cmd_type    = t;
    cmd_opcode  = op;
    cmd_operand = d;
    cmd_count   = n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int csoe,
                          output int drv);
    lat = 0; csoe = 0; drv = 0;
    while (!rsp_valid && lat < 40) begin
      if (acc_cs && acc_oe) csoe++;
      if (acc_bus_drive) drv++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    `CHK("rsp_valid_drop", rsp_valid, 1'b0)
    `CHK("cmd_ready_after", cmd_ready, 1'b1)
  endtask

  task automatic run(input string nm, input logic [1:0] t,
                     input logic [OW-1:0] op, input logic [DW-1:0] d,
                     input logic [CW-1:0] n, input int e_lat,
                     input logic [DW-1:0] e_data, input int e_we,
                     input int e_alu);
    int lat, csoe, drv, we0, alu0;
    we0 = we_p; alu0 = alu_p;
    start(t, op, d, n);
    wait_rsp(lat, csoe, drv);
    `CHK({nm, "_latency"}, lat, e_lat)
    `CHK({nm, "_data"}, rsp_data, e_data)
    `CHK({nm, "_we_pulses"}, we_p - we0, e_we)
    `CHK({nm, "_alu_pulses"}, alu_p - alu0, e_alu)
    finish_rsp();
  endtask

  logic [3:0] exp_st;
  int lat, csoe, drv, bad;

  initial begin
`ifdef ACC_SEQ_STATUS_LATCH_EN
    exp_st = 4'h3;
`else
    exp_st = 4'h0;
`endif
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_cmd_ready", cmd_ready, 1'b1)
    `CHK("rst_rsp_valid", rsp_valid, 1'b0)
    `CHK("rst_opcode", acc_alu_opcode, ALU_OP_LD)
    `CHK("rst_we", acc_we, 1'b0)
    `CHK("rst_status", rsp_status, 4'h0)
    reset = 1'b0;
    @(posedge clk);
    #1;

    run("load5a", CMD_LOAD, 5'h00, 8'h5A, 4'd0, 3, 8'h5A, 1, 0);
    `CHK("model_q_5a", q, 8'h5A)
    run("load03", CMD_LOAD, 5'h00, 8'h03, 4'd0, 3, 8'h03, 1, 0);
    run("add3", CMD_ALU, ALU_OP_ADD, 8'h04, 4'd3, 5, 8'h0F, 0, 3);
    run("cnt0", CMD_ALU, ALU_OP_ADD, 8'h01, 4'd0, 3, 8'h10, 0, 1);
    run("cnt1", CMD_ALU, ALU_OP_ADD, 8'h01, 4'd1, 3, 8'h11, 0, 1);

    run("loadff", CMD_LOAD, 5'h00, 8'hFF, 4'd0, 3, 8'hFF, 1, 0);
    run("wrap", CMD_ALU, ALU_OP_ADD, 8'h01, 4'd1, 3, 8'h00, 0, 1);
    `CHK("wrap_status", rsp_status, exp_st)
    run("load20", CMD_LOAD, 5'h00, 8'h20, 4'd0, 3, 8'h20, 1, 0);
    `CHK("status_held", rsp_status, exp_st)
    run("nop", CMD_NOP, 5'h00, 8'hEE, 4'd5, 1, 8'h20, 0, 0);

    // READ with delayed consumer
    start(CMD_READ, 5'h00, 8'h00, 4'd0);
    wait_rsp(lat, csoe, drv);
    `CHK("read_latency", lat, 3)
    `CHK("read_csoe_cycles", csoe, 2)
    `CHK("read_no_drive", drv, 0)
    `CHK("read_data", rsp_data, 8'h20)
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      `CHK("read_hold_valid", rsp_valid, 1'b1)
      `CHK("read_hold_data", rsp_data, 8'h20)
      `CHK("read_hold_ready", cmd_ready, 1'b0)
      `CHK("read_hold_cs", acc_cs, 1'b0)
    end
    finish_rsp();

    // Reset in the middle of an 8-iteration ALU command
    start(CMD_ALU, ALU_OP_ADD, 8'h01, 4'd8);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    `CHK("mid_alu_en", acc_alu_en, 1'b1)
    reset = 1'b1;
    #1;
    `CHK("rst_alu_en_drop", acc_alu_en, 1'b0)
    `CHK("rst_mid_opcode", acc_alu_opcode, ALU_OP_LD)
    `CHK("rst_mid_input", acc_alu_input, 8'h00)
    @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || acc_alu_en || !cmd_ready) bad++;
    end
    `CHK("rst_no_response", bad, 0)
    run("recover", CMD_LOAD, 5'h00, 8'h77, 4'd0, 3, 8'h77, 1, 0);
    `CHK("never_both_strobes", both_p, 0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Command-driven controller for the CPU accumulator. It accepts LOAD / ALU / READ commands over a valid/ready handshake and drives the accumulator's chip-select, write, output-enable, ALU-enable and opcode lines with correctly timed strobes. It supports repeated ALU operations via an iteration counter, and returns the result and ALU status over a response handshake. It sits between the control unit (or a test master) and the accumulator, and is the sole driver of the accumulator's control pins.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH: accumulator word width.
- OPCODE_WIDTH, default `OPCODEWORD_ALU_OPCODE_WIDTH (5): ALU opcode width.
- CNT_WIDTH, default 4: width of the ALU repeat count.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  0=LOAD, 1=ALU, 2=READ, 3=reserved (NOP).
- cmd_opcode  in  OPCODE_WIDTH  ALU opcode (ALU commands only).
- cmd_operand  in  DATA_WIDTH  LOAD data or ALU port-B operand.
- cmd_count  in  CNT_WIDTH  ALU repetitions; 0 is treated as 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  accumulator value after the command.
- rsp_status  out  4  ALU status (see Configuration).
- acc_cs, acc_we, acc_oe, acc_alu_en  out  1 each  accumulator controls.
- acc_alu_opcode  out  OPCODE_WIDTH  to accumulator alu_opcode.
- acc_alu_input  out  DATA_WIDTH  to accumulator alu_input.
- acc_bus_data  out  DATA_WIDTH  value to drive on the shared data bus.
- acc_bus_drive  out  1  enable for the top-level bus driver.
- acc_data_out  in  DATA_WIDTH  accumulator Q.
- acc_status  in  4  accumulator alu_status.

## Operation
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) registers type, opcode, operand and count.
  - cmd_count=0 is loaded as 1.
  - NOP goes directly to RESP.
- SETUP (1 cycle): drive operands with all strobes low.
  - LOAD: acc_bus_data=operand, acc_bus_drive=1, acc_alu_opcode=ALU_OP_LD. The accumulator requires opcode=LD whenever WE is high.
  - ALU: acc_alu_input=operand, acc_alu_opcode=cmd_opcode.
  - READ: acc_cs=acc_oe=1.
- STROBE: all operand and bus values are held stable.
  - LOAD: acc_we=1 for one cycle.
  - ALU: acc_alu_en=1 for N cycles. A down-counter holds the remaining iterations; exit when it reaches 1.
  - READ: acc_cs=acc_oe=1 for one cycle, then go to RESP.
- RESP: rsp_valid=1, rsp_data=acc_data_out; hold until rsp_ready, then return to IDLE.
  - acc_bus_drive drops on entry to RESP.
  - acc_alu_opcode returns to ALU_OP_LD.
- acc_we and acc_alu_en are never high together. acc_bus_drive is never high during READ.
- Reserved cmd_type is handled as a NOP: no strobes, rsp_data equals current Q.

## Timing
- The accumulator clocks on clk & (WE | ALU_EN). To avoid gated-clock glitches, acc_we and acc_alu_en are registered on the falling edge of clk.
  - Each strobe is asserted at the negedge before the capturing posedge and deasserted at the following negedge.
  - All other outputs are posedge-registered.
- Latency, counted from the command handshake at edge k to rsp_valid high:
  - LOAD: after edge k+3.
  - READ: after edge k+3.
  - ALU: after edge k+2+N.
  - NOP: after edge k+1.
- Consecutive ALU iterations: the counter decrements on each posedge in STROBE.
- Back-to-back commands: cmd_ready rises the cycle after the response handshake. There is no pipelining.
- rsp_data and rsp_status are stable while rsp_valid is high and rsp_ready is low.
- Reset (asynchronous, including mid-command):
  - State goes to IDLE; all acc_* strobes, acc_bus_drive and rsp_valid go to 0 immediately.
  - acc_alu_opcode goes to ALU_OP_LD; acc_bus_data, acc_alu_input, rsp_data and rsp_status go to 0.
  - cmd_ready is 1 after reset.
  - An in-flight command is dropped without a response.

## Configuration
- Macro ACC_SEQ_STATUS_LATCH_EN.
- Defined: acc_status is sampled on the posedge in the final STROBE cycle of an ALU command. This captures the flags of the last operation, before Q updates. The value is held in rsp_status until the next ALU command; LOAD and READ leave it unchanged.
- Undefined: rsp_status is tied to 0 and the status register is removed.

## Structure
- Shared package constants:
  - CMD_LOAD, CMD_ALU, CMD_READ, CMD_NOP.
  - ALU_OP_LD, taken from the common ALU opcode table.
  - STATUS_WIDTH=4.
  - FSM state encodings.
- Sub-module acc_strobe_gen: negedge-registered generation of acc_we / acc_alu_en from the posedge FSM state, with asynchronous reset to 0.

## Test plan
- Reset, then LOAD operand 0x5A -> acc_we pulses once, accumulator Q=0x5A, rsp_valid at k+3 with rsp_data=0x5A.
- LOAD 0x03, then ALU ADD operand 0x04 count 3 -> three acc_alu_en pulses, rsp_data=0x0F, latency k+5.
- ALU with count 0 -> exactly one acc_alu_en pulse, same result as count 1.
- With ACC_SEQ_STATUS_LATCH_EN: LOAD 0xFF, then ALU ADD 0x01 -> rsp_data=0x00 with carry/zero set in rsp_status. Without the macro, rsp_status=0.
- READ while rsp_ready is held low for 4 cycles -> acc_cs/acc_oe high for the SETUP and STROBE cycles only; rsp_valid and rsp_data are held; cmd_ready stays 0 until the response handshake.
- Assert reset during STROBE of an ALU count-8 command -> strobes drop within the same cycle, no response, cmd_ready=1 after reset is released.
